// File: rtl/tmds_pkg.sv
// tmds_pkg: TMDS control tokens and alignment state shared by encoder and decoder
package tmds_pkg;
  localparam logic [9:0] TMDS_CTRL_00 = 10'b1101010100;
  localparam logic [9:0] TMDS_CTRL_01 = 10'b0010101011;
  localparam logic [9:0] TMDS_CTRL_10 = 10'b0101010100;
  localparam logic [9:0] TMDS_CTRL_11 = 10'b1010101011;
  typedef enum logic {SEARCH, LOCKED} tmds_align_state_t;
  function automatic logic is_ctrl(input logic [9:0] s);
    return s == TMDS_CTRL_00 || s == TMDS_CTRL_01 || s == TMDS_CTRL_10 || s == TMDS_CTRL_11;
  endfunction
endpackage

// File: rtl/tmds_symbol_decode.sv
// tmds_symbol_decode: combinational 10b TMDS symbol to video byte or control pair
module tmds_symbol_decode
  import tmds_pkg::*;
(
  input  logic [9:0] sym,
  output logic       vde,
  output logic [7:0] vd,
  output logic [1:0] cd
);
  logic [7:0] d;
  logic ctrl;
  assign ctrl = is_ctrl(sym);
  assign d = sym[9] ? ~sym[7:0] : sym[7:0];
  assign vde = !ctrl;
  // bit 8 selects XOR (1) or XNOR (0) chaining used by the encoder
  assign vd = ctrl ? 8'h00 : {d[7:1] ^ d[6:0] ^ {7{~sym[8]}}, d[0]};
  assign cd = !ctrl ? 2'b00 : sym == TMDS_CTRL_00 ? 2'b00 : sym == TMDS_CTRL_01 ? 2'b01 :
              sym == TMDS_CTRL_10 ? 2'b10 : 2'b11;
endmodule

// File: rtl/tmds_channel_decoder.sv
// tmds_channel_decoder: one DVI lane, bit-slip word alignment on control-token runs plus symbol decode
module tmds_channel_decoder
  import tmds_pkg::*;
#(
  parameter int CTRL_RUN      = 8,
  parameter int SEARCH_WINDOW = 2048,
  parameter int LOCK_TIMEOUT  = 4096
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  input  logic [9:0] raw_sym,
  output logic       out_valid,
  output logic       vde,
  output logic [7:0] vd,
  output logic [1:0] cd,
  output logic       locked,
  output logic [3:0] slip_offset,
  output logic       lock_lost
);
  localparam int RW = $clog2(CTRL_RUN) + 1;
  localparam int SW = $clog2(SEARCH_WINDOW) + 1;
  localparam int GW = $clog2(LOCK_TIMEOUT) + 1;
  tmds_align_state_t state, state_n;
  logic [9:0] prev, sym, aligned;
  logic [RW-1:0] run_cnt, run_n;
  logic [SW-1:0] search_cnt, search_n;
  logic [GW-1:0] gap_cnt, gap_n;
  logic [3:0] offset_n;
  logic lost_n, dec_vde;
  logic [7:0] dec_vd;
  logic [1:0] dec_cd;
  assign aligned = 10'({raw_sym, prev} >> slip_offset);
  assign locked = state == LOCKED;
  tmds_symbol_decode u_dec (.sym(sym), .vde(dec_vde), .vd(dec_vd), .cd(dec_cd));
  always_comb begin
    state_n = state;
    run_n = run_cnt;
    search_n = search_cnt;
    gap_n = gap_cnt;
    offset_n = slip_offset;
    lost_n = 1'b0;
    if (state == SEARCH) begin
      if (!dec_vde && run_cnt == RW'(CTRL_RUN - 1)) begin
        state_n = LOCKED;
        run_n = '0;
        search_n = '0;
        gap_n = '0;
      end else if (search_cnt == SW'(SEARCH_WINDOW - 1)) begin
        offset_n = slip_offset == 4'd9 ? 4'd0 : slip_offset + 4'd1;
        search_n = '0;
        run_n = '0;
      end else begin
        search_n = search_cnt + 1'b1;
        run_n = dec_vde ? '0 : run_cnt + 1'b1;
      end
    end else if (!dec_vde) gap_n = '0;
    else if (gap_cnt == GW'(LOCK_TIMEOUT - 1)) begin
      state_n = SEARCH;
      lost_n = 1'b1;
      gap_n = '0;
    end else gap_n = gap_cnt + 1'b1;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= SEARCH;
      prev <= '0;
      sym <= '0;
      run_cnt <= '0;
      search_cnt <= '0;
      gap_cnt <= '0;
      slip_offset <= '0;
      out_valid <= 1'b0;
      lock_lost <= 1'b0;
      vde <= 1'b0;
      vd <= '0;
      cd <= '0;
    end else begin
      out_valid <= in_valid && state_n == LOCKED;
      lock_lost <= in_valid && lost_n;
      if (in_valid) begin
        prev <= raw_sym;
        sym <= aligned;
        state <= state_n;
        run_cnt <= run_n;
        search_cnt <= search_n;
        gap_cnt <= gap_n;
        slip_offset <= offset_n;
        vde <= dec_vde;
        vd <= dec_vd;
        cd <= dec_cd;
      end
    end
endmodule

// File: tb/tb_tmds_channel_decoder.sv
// tb_tmds_channel_decoder: encoder-driven bit stream, lane model and output scoreboard
module tb_tmds_channel_decoder;
  logic clk = 1'b0, reset = 1'b0, in_valid = 1'b0;
  logic [9:0] raw_sym = '0;
  logic out_valid, vde, locked, lock_lost;
  logic [7:0] vd;
  logic [1:0] cd;
  logic [3:0] slip_offset;
  always #5 clk = ~clk;
  tmds_channel_decoder dut (.clk(clk), .reset(reset), .in_valid(in_valid), .raw_sym(raw_sym),
    .out_valid(out_valid), .vde(vde), .vd(vd), .cd(cd), .locked(locked),
    .slip_offset(slip_offset), .lock_lost(lock_lost));
  logic [9:0] tok_tab [4] = '{10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011};
  int total = 0, bad = 0, pops = 0, lost_seen = 0, nw = 0, disp = 0;
  bit bits[$];
  int meta[int];
  int expq[$];
  bit mix = 0;
  bit m_locked, m_lost;
  int m_off, m_run, m_win, m_gap, m_meta;
  logic [9:0] m_sym;
  function automatic void check(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction
  // reference DVI encoder with running disparity
  function automatic logic [9:0] tmds_enc(input logic [7:0] d);
    logic [8:0] qm;
    int n1q, n0q;
    bit xn;
    logic [9:0] q;
    xn = $countones(d) > 4 || ($countones(d) == 4 && !d[0]);
    qm[0] = d[0];
    for (int i = 1; i < 8; i++) qm[i] = xn ? ~(qm[i-1] ^ d[i]) : qm[i-1] ^ d[i];
    qm[8] = !xn;
    n1q = $countones(qm[7:0]);
    n0q = 8 - n1q;
    if (disp == 0 || n1q == n0q) begin
      q = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
      disp += qm[8] ? n1q - n0q : n0q - n1q;
    end else if ((disp > 0 && n1q > n0q) || (disp < 0 && n0q > n1q)) begin
      q = {1'b1, qm[8], ~qm[7:0]};
      disp += 2 * int'(qm[8]) + n0q - n1q;
    end else begin
      q = {1'b0, qm[8], qm[7:0]};
      disp += -2 * int'(!qm[8]) + n1q - n0q;
    end
    return q;
  endfunction
  function automatic logic [9:0] word_at(input int p);
    logic [9:0] w;
    for (int i = 0; i < 10; i++) w[i] = (p + i < 0 || p + i >= bits.size()) ? 1'b0 : bits[p + i];
    return w;
  endfunction
  function automatic int meta_at(input int p);
    return meta.exists(p) ? meta[p] : -1;
  endfunction
  function automatic void add_sym(input logic [9:0] w, input int m);
    meta[bits.size()] = m;
    for (int i = 0; i < 10; i++) bits.push_back(w[i]);
  endfunction
  function automatic bit is_tok(input logic [9:0] w);
    return w == tok_tab[0] || w == tok_tab[1] || w == tok_tab[2] || w == tok_tab[3];
  endfunction
  task automatic step(input bit v);
    int p;
    @(negedge clk);
    in_valid = v;
    m_lost = 0;
    if (v) begin
      raw_sym = word_at(10 * nw);
      p = 10 * (nw - 1) + m_off;
      if (!m_locked) begin
        if (is_tok(m_sym) && m_run == 7) begin
          m_locked = 1; m_gap = 0; m_run = 0; m_win = 0;
        end else if (m_win == 2047) begin
          m_off = (m_off + 1) % 10; m_win = 0; m_run = 0;
        end else begin
          m_win++; m_run = is_tok(m_sym) ? m_run + 1 : 0;
        end
      end else if (is_tok(m_sym)) m_gap = 0;
      else if (m_gap == 4095) begin
        m_locked = 0; m_lost = 1; m_gap = 0;
      end else m_gap++;
      if (m_locked) expq.push_back(m_meta);
      m_sym = word_at(p);
      m_meta = meta_at(p);
      nw++;
    end
    @(posedge clk);
    #1;
    if (lock_lost) lost_seen++;
    check("lock_state", {locked, slip_offset, lock_lost}, {m_locked, 4'(m_off), m_lost});
  endtask
  task automatic toks(input int c, input int n);
    repeat (n) begin
      if (mix && $urandom_range(0, 7) == 0) step(0);
      disp = 0;
      add_sym(tok_tab[c < 0 ? $urandom_range(0, 3) : c], 0);
      meta[bits.size() - 10] = int'(word_at(bits.size() - 10) == tok_tab[1]) +
        2 * int'(word_at(bits.size() - 10) == tok_tab[2]) + 3 * int'(word_at(bits.size() - 10) == tok_tab[3]);
      step(1);
    end
  endtask
  task automatic send_byte(input logic [7:0] b);
    add_sym(tmds_enc(b), (1 << 10) | (int'(b) << 2));
    step(1);
  endtask
  task automatic do_reset(input int k);
    #2 reset = 1'b1;
    #1 check("async_reset_outputs", {out_valid, vde, vd, cd, locked, slip_offset, lock_lost}, 0);
    bits.delete(); meta.delete(); expq.delete();
    nw = 0; disp = 0; m_locked = 0; m_lost = 0; m_off = 0; m_run = 0; m_win = 0; m_gap = 0;
    m_sym = '0; m_meta = -1;
    repeat (k) bits.push_back(1'($urandom));
    @(negedge clk);
    reset = 1'b0;
    in_valid = 1'b0;
  endtask
  initial forever begin
    @(posedge clk);
    #1;
    if (out_valid) begin
      if (expq.size() == 0) check("out_valid_with_empty_scoreboard", out_valid, 0);
      else begin
        int e;
        e = expq.pop_front();
        pops++;
        if (e >= 0) check("decoded_symbol", {vde, vd, cd}, e);
      end
    end
  end
  initial begin
    int off_before;
    do_reset(0);
    toks(0, 16);
    check("t1_locked", locked, 1);
    check("t1_offset", slip_offset, 0);
    add_sym(10'h100, 1 << 10);
    step(1);
    for (int i = 0; i < 256; i++) begin
      send_byte(8'($urandom));
      send_byte(8'(i * 37 + 11));
      if (i % 32 == 31) toks(-1, 2);
    end
    repeat (4098) send_byte(8'($urandom));
    check("t4_lost_pulses", lost_seen, 1);
    check("t4_unlocked", locked, 0);
    check("t4_offset_held", slip_offset, 0);
    toks(0, 12);
    check("t4_relocked", locked, 1);
    repeat (4095) send_byte(8'($urandom));
    toks(2, 3);
    check("t5_lock_retained", locked, 1);
    check("t5_no_extra_lost", lost_seen, 1);
    repeat (5) send_byte(8'($urandom));
    do_reset(3);
    mix = 1;
    for (int i = 0; i < 6400 && !locked; i++) begin
      if (i == 3000) begin
        off_before = slip_offset;
        repeat (100) step(0);
        check("idle_offset_hold", slip_offset, off_before);
      end
      toks(0, 1);
    end
    check("t3_locked", locked, 1);
    check("t3_offset", slip_offset, 3);
    for (int i = 0; i < 40; i++) begin
      toks(-1, 1);
      send_byte(8'($urandom));
    end
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("scoreboard_drained", expq.size(), 0);
    check("outputs_seen", int'(pops > 500), 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
